// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Contents: FSM state type and encodings, requester count, index width.
package arb_pkg;

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDXW = 3;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/dec3to8_en.sv
// Enabled 3-to-8 one-hot decoder (combinational).
// Ports:
//   idx    - binary select index
//   en     - when low, output is all zeros
//   onehot - decoded one-hot vector
module dec3to8_en
  import arb_pkg::*;
(
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [NREQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter driving a registered one-hot grant.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   en          - enable; low blocks new grants and releases the current one
//   req[7:0]    - request vector
//   done        - current holder finished (looked at only while granted)
//   gnt[7:0]    - registered one-hot grant
//   gnt_idx     - index of the current or most recent winner
//   gnt_valid   - high while gnt is non-zero
//   timeout_err - one-cycle pulse when a grant is released only by the hold limit
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout_err
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  state_t          state, state_n;
  logic [IDXW-1:0] ptr, ptr_n;
  logic [IDXW-1:0] idx_n;
  logic            valid_n;
  logic            to_n;
  logic [CW-1:0]   hold_cnt, cnt_n;
  logic [NREQ-1:0] gnt_n;

  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] cand;
  logic            at_limit;
  logic            holder_req;
  logic            release_now;

  // Round-robin search: scan from the highest offset down so the lowest
  // offset from ptr (the nearest requester) is the last one assigned.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + IDXW'(k);
      if (req[cand]) winner = cand;
    end
  end

  assign at_limit    = (hold_cnt == CW'(MAX_HOLD));
  assign holder_req  = req[gnt_idx];
  assign release_now = done | ~holder_req | ~en | at_limit;

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    valid_n = gnt_valid;
    to_n    = 1'b0;
    cnt_n   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (en && (|req)) begin
          state_n = ST_GRANT;
          idx_n   = winner;
          valid_n = 1'b1;
          cnt_n   = CW'(1);
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
          ptr_n   = gnt_idx + IDXW'(1);
          cnt_n   = '0;
          // Error only when the hold limit is the sole reason for release.
          to_n    = at_limit & ~done & holder_req & en;
        end else begin
          cnt_n   = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  // Grant is decoded from the next-state index so it can be registered.
  dec3to8_en u_dec (
    .idx    (idx_n),
    .en     (valid_n),
    .onehot (gnt_n)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt         <= '0;
      gnt_idx     <= '0;
      gnt_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= cnt_n;
      gnt         <= gnt_n;
      gnt_idx     <= idx_n;
      gnt_valid   <= valid_n;
      timeout_err <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (instantiated with MAX_HOLD=4).
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout_err;

  int checks;
  int errors;

  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the resource, for how long, and where the
  // next search starts.
  int m_holder;  // -1 when nobody holds it
  int m_ptr;
  int m_held;
  int m_last;
  int m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_holder = -1; m_ptr = 0; m_held = 0; m_last = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_holder < 0) begin
        if (en && req != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (req[(m_ptr + k) % 8]) begin
              m_holder = (m_ptr + k) % 8;
              break;
            end
          end
          m_last = m_holder;
          m_held = 1;
        end
      end else begin
        if (done || !req[m_holder] || !en || m_held == MAXH) begin
          if (m_held == MAXH && !done && req[m_holder] && en) m_to = 1;
          m_ptr    = (m_holder + 1) % 8;
          m_holder = -1;
        end else begin
          m_held = m_held + 1;
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_gnt", 32'(gnt), (m_holder < 0) ? 32'h0 : (32'h1 << m_holder));
      chk("cyc_idx", 32'(gnt_idx), 32'(m_last));
      chk("cyc_valid", 32'(gnt_valid), (m_holder < 0) ? 32'h0 : 32'h1);
      chk("cyc_to", 32'(timeout_err), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; req = 8'h00; done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;
    #2;
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_idx", 32'(gnt_idx), 32'h0);

    // Single request and release; next search starts at 6.
    en = 1'b1; req = 8'h20;
    tick();
    chk("single_gnt", 32'(gnt), 32'h20);
    chk("single_idx", 32'(gnt_idx), 32'd5);
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'hFF;
    chk("single_rel", 32'(gnt), 32'h00);
    tick();
    chk("ptr6_idx", 32'(gnt_idx), 32'd6);
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h81;

    // Wrap: ptr=7, req=81 -> 7, dead cycle, then 0.
    tick();
    chk("wrap_g7", 32'(gnt), 32'h80);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("wrap_dead", 32'(gnt), 32'h00);
    tick();
    chk("wrap_g0", 32'(gnt), 32'h01);
    chk("wrap_idx0", 32'(gnt_idx), 32'd0);
    req = 8'h00;
    tick();

    // Full contention from a fresh pointer.
    do_reset();
    en = 1'b1; req = 8'hFF; done = 1'b1;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk("rr_idx", 32'(gnt_idx), 32'(g % 8));
      chk("rr_gnt", 32'(gnt), 32'h1 << (g % 8));
      tick();
      chk("rr_dead", 32'(gnt), 32'h00);
    end
    req = 8'h00; done = 1'b0;
    tick();

    // Timeout: held exactly MAX_HOLD cycles then one error pulse.
    do_reset();
    begin
      int held;
      int pulses;
      held = 0; pulses = 0;
      en = 1'b1; req = 8'h02;
      for (int c = 0; c < 12 && (held == 0 || gnt_valid); c++) begin
        tick();
        if (gnt == 8'h02) held++;
        if (timeout_err) pulses++;
      end
      req = 8'h00;
      chk("to_held", 32'(held), 32'd4);
      chk("to_pulse_now", 32'(timeout_err), 32'h1);
      tick();
      if (timeout_err) pulses++;
      chk("to_pulses", 32'(pulses), 32'd1);
    end

    // Same, but done on the 4th held cycle: no error.
    do_reset();
    en = 1'b1; req = 8'h02;
    tick(); tick(); tick(); tick();
    chk("tod_held4", 32'(gnt), 32'h02);
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;
    chk("tod_rel", 32'(gnt), 32'h00);
    chk("tod_noerr", 32'(timeout_err), 32'h0);
    tick();

    // Enable drop during a grant.
    do_reset();
    en = 1'b1; req = 8'h01;
    tick();
    chk("en_gnt", 32'(gnt), 32'h01);
    en = 1'b0;
    tick();
    chk("en_rel", 32'(gnt), 32'h00);
    chk("en_noerr", 32'(timeout_err), 32'h0);

    // Withdrawal during a grant.
    en = 1'b1;
    tick();
    chk("wd_gnt", 32'(gnt), 32'h01);
    req = 8'h00;
    tick();
    chk("wd_rel", 32'(gnt), 32'h00);
    chk("wd_noerr", 32'(timeout_err), 32'h0);

    // Disabled while idle: nothing granted.
    en = 1'b0; req = 8'hFF;
    tick(); tick(); tick();
    chk("dis_gnt", 32'(gnt), 32'h00);
    chk("dis_valid", 32'(gnt_valid), 32'h0);

    // Reset in the middle of a grant clears outputs without a clock.
    en = 1'b1; req = 8'h04;
    tick();
    chk("mid_gnt", 32'(gnt), 32'h04);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h00);
    chk("mid_rst_valid", 32'(gnt_valid), 32'h0);
    chk("mid_rst_idx", 32'(gnt_idx), 32'h0);
    chk("mid_rst_to", 32'(timeout_err), 32'h0);
    tick();
    rst_n = 1'b1;
    req = 8'h00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one decoded resource (one-hot select bus) among eight requesters.
- Each cycle the arbiter selects a 3-bit winner index, holds it for one transaction, and drives the one-hot grant through an enabled 3-to-8 decoder stage.
- Sits in front of any shared 8-way resource (bus, memory bank, output mux) whose select is a one-hot vector.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range 2..255.
- CW, $clog2(MAX_HOLD+1), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable; low blocks new grants and forces release of the current grant.
- req  input  8  request vector; bit i high = requester i wants the resource.
- done  input  1  the current grant holder finishes; sampled only in GRANT.
- gnt  output  8  one-hot grant, registered; all zeros when no grant.
- gnt_idx  output  3  binary index of the current or last winner.
- gnt_valid  output  1  high while gnt is non-zero.
- timeout_err  output  1  one-cycle pulse when a grant is force-released by the MAX_HOLD limit.

Behaviour:
- Reset (async, rst_n low): state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout_err=0, ptr=3'd0, hold_cnt=0.
- Outputs remain at these values until the first rising clk after rst_n deasserts.
- State machine states: IDLE, GRANT.
- IDLE: if en && |req, winner = first set bit of req searching ptr, ptr+1, ... mod 8 (wrap 7->0).
  - Next edge: gnt_idx=winner, gnt=decode(winner), gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency req->gnt: 1 cycle.
  - Otherwise stay in IDLE with gnt=0.
- GRANT: hold_cnt increments each cycle. Release occurs on the next edge when any of the following holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0 (requester withdrew);
  - (c) en=0;
  - (d) hold_cnt==MAX_HOLD.
- On release: gnt=0, gnt_valid=0, ptr=gnt_idx+1 (mod 8), state=IDLE.
  - gnt_idx keeps the last winner.
  - This leaves one mandatory dead cycle between consecutive grants.
- timeout_err=1 for exactly one cycle (the release edge) only when (d) is the sole release cause. If done or a withdrawal coincides with (d), no error is flagged.
- Requests by other requesters during GRANT are ignored; they are arbitrated in IDLE.
- Requests in the dead cycle are seen at that IDLE cycle.
- gnt is always zero or one-hot; gnt_valid == |gnt at all times.
- en low in IDLE: no grant; ptr unchanged.
- Reset mid-GRANT: immediate async clear to reset values; no timeout_err pulse.
- Fairness: with all 8 requests held constantly and done pulsed each grant, winners cycle 0,1,...,7,0.

Decomposition:
- Shared package arb_pkg holds:
  - state typedef (IDLE, GRANT);
  - NREQ=8;
  - IDXW=3.
- One sub-module: dec3to8_en (combinational enabled 3-to-8 decoder). Its input is the next-state index and its enable is the next-state grant-valid; its output is registered into gnt.
- The round-robin priority search stays inline in rr_arbiter8.

Test Plan:
- Reset: rst_n low mid-GRANT with gnt=8'h04 -> gnt=8'h00, gnt_valid=0, gnt_idx=0, timeout_err=0 immediately, without waiting for clk.
- Single request: en=1, req=8'h20 -> next edge gnt=8'h20, gnt_idx=5; done pulse -> gnt=8'h00 next edge, ptr=6.
- Round-robin wrap: ptr=7, req=8'h81 -> grant 7; after release with req still 8'h81 -> grant 0 after one dead cycle.
- Full contention: req=8'hFF held, done pulsed each grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0; each grant separated by one zero cycle.
- Timeout: MAX_HOLD=4, req=8'h02 held, done=0 -> gnt held 4 cycles, then gnt=0 with a single timeout_err pulse; same run with done=1 on cycle 4 -> no timeout_err.
- Enable/withdraw: during GRANT drop en -> gnt=0 next edge; during GRANT with req=8'h01 drop to 8'h00 -> release, no error; en=0 in IDLE with req=8'hFF -> gnt stays 8'h00.
